// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program counter with a return-address stack. Optional FAULT
//            parking on stack misuse is enabled by defining STACK_FAULT_EN.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH    = 5,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                jmp,
    input  logic                cal,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    input  logic                fault_clr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [SP_WIDTH-1:0] sp,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                fault
);

    localparam int                  c_idx_w   = $clog2(STACK_DEPTH);
    localparam logic [SP_WIDTH-1:0] c_sp_full = SP_WIDTH'(STACK_DEPTH);
    localparam logic [SP_WIDTH-1:0] c_sp_one  = SP_WIDTH'(1);

    logic [PC_WIDTH-1:0] r_pc;
    logic [SP_WIDTH-1:0] r_sp;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_top;
    logic [SP_WIDTH-1:0] w_sp_nxt;
    logic [c_idx_w-1:0]  w_top_idx;
    logic [c_idx_w-1:0]  w_push_idx;
    logic                w_push;
    logic                w_full;
    logic                w_empty;

    assign w_full     = (r_sp == c_sp_full);
    assign w_empty    = (r_sp == '0);
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    // Index is forced to 0 when empty so the read never leaves the array.
    assign w_top_idx  = w_empty ? '0 : c_idx_w'(r_sp - c_sp_one);
    assign w_push_idx = c_idx_w'(r_sp);
    assign w_top      = r_stack[w_top_idx];

`ifdef STACK_FAULT_EN
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_sp_nxt    = r_sp;
        w_push      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (en) begin
                    if (ret) begin
                        if (w_empty) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_pc_nxt = w_top;
                            w_sp_nxt = r_sp - c_sp_one;
                        end
                    end else if (cal) begin
                        if (w_full) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = jmp_addr;
                            w_sp_nxt = r_sp + c_sp_one;
                        end
                    end else if (jmp) begin
                        w_pc_nxt = jmp_addr;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            ST_FAULT: begin
                // Soft restart; the stack contents are left as don't-care.
                if (fault_clr) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_sp_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign fault = (r_state == ST_FAULT);
`else
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = fault_clr;

    always_comb begin
        w_pc_nxt = r_pc;
        w_sp_nxt = r_sp;
        w_push   = 1'b0;
        if (en) begin
            if (ret && !w_empty) begin
                w_pc_nxt = w_top;
                w_sp_nxt = r_sp - c_sp_one;
            end else if (ret) begin
                w_pc_nxt = w_pc_inc;
            end else if (cal) begin
                // A call on a full stack still jumps; only the push is lost.
                w_pc_nxt = jmp_addr;
                if (!w_full) begin
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + c_sp_one;
                end
            end else if (jmp) begin
                w_pc_nxt = jmp_addr;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_sp <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            r_sp <= w_sp_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc          = r_pc;
    assign sp          = r_sp;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule
`default_nettype wire
